// File: rtl/reg_check_harness.sv
// reg_check_harness: start-triggered processor run, then regfile scan vs ROM.
// Optional writeback monitor built when REGCHK_WB_MONITOR_EN is defined.
module reg_check_harness #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_REGS     = 32,
  parameter int CYCLE_W      = 16,
  parameter int READ_LATENCY = 0,
  parameter int ADDR_W       = $clog2(NUM_REGS),
  parameter int ERR_W        = $clog2(NUM_REGS + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CYCLE_W-1:0]    run_cycles,
  output logic                  cpu_reset,
  output logic                  cpu_en,
  output logic                  test_mode,
  output logic [ADDR_W-1:0]     test_reg,
  input  logic [DATA_WIDTH-1:0] reg_data,
  input  logic [DATA_WIDTH-1:0] exp_data,
`ifdef REGCHK_WB_MONITOR_EN
  input  logic                  wb_we,
  input  logic [ADDR_W-1:0]     wb_rd,
  output logic [CYCLE_W-1:0]    wb_count,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_W-1:0]      error_count,
  output logic [ADDR_W-1:0]     first_fail_reg,
  output logic [CYCLE_W-1:0]    cycle_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CPURST = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_SCAN   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [1:0] LAT     = 2'(READ_LATENCY);
  localparam logic [1:0] LAT_ONE = 2'd1;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

  localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

  localparam logic [CYCLE_W:0] CYC_ONE = (CYCLE_W + 1)'(1);

  logic [2:0]         state;
  logic [2:0]         state_nx;
  logic               start_q;
  logic               accept;
  logic               enter_rst;
  logic               idle_like;
  logic [CYCLE_W-1:0] run_len;
  logic               run_zero;
  logic [CYCLE_W:0]   cyc_inc;
  logic               run_end;
  logic [1:0]         lat_cnt;
  logic               cmp_now;
  logic               last_reg;
  logic               mismatch;
  logic               scan_hit;
  logic [ERR_W-1:0]   err_nx;
  logic [ADDR_W-1:0]  ff_nx;

  assign idle_like = (state == S_IDLE) ||
                     (state == S_DONE);

  // A start is taken once, only when no test is running.
  assign accept = start && !start_q && idle_like;

  // The clear of results coincides with the CPURST entry edge.
  assign enter_rst = start_q && idle_like;

  assign run_zero = (run_len == '0);

  // One extra bit keeps an all-ones run length from wrapping.
  assign cyc_inc = {1'b0, cycle_count} + CYC_ONE;
  assign run_end = (cyc_inc == {1'b0, run_len});

  assign cmp_now  = (lat_cnt == LAT);
  assign last_reg = (test_reg == LAST_IDX);
  assign mismatch = (reg_data != exp_data);
  assign scan_hit = (state == S_SCAN) && cmp_now;

  // Sequencer next state.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (start_q) state_nx = S_CPURST;
      end
      S_CPURST: begin
        state_nx = run_zero ? S_SCAN : S_RUN;
      end
      S_RUN: begin
        if (run_end) state_nx = S_SCAN;
      end
      S_SCAN: begin
        if (cmp_now && last_reg) state_nx = S_DONE;
      end
      S_DONE: begin
        if (start_q) state_nx = S_CPURST;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Start capture and run-length latch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      start_q <= 1'b0;
      run_len <= '0;
    end else begin
      start_q <= accept;
      if (accept) run_len <= run_cycles;
    end
  end

  // Processor control and status outputs decoded from the next state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cpu_reset <= 1'b1;
      cpu_en    <= 1'b0;
      test_mode <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      cpu_reset <= (state_nx == S_IDLE) ||
                   (state_nx == S_CPURST);
      cpu_en    <= (state_nx == S_RUN);
      test_mode <= (state_nx == S_SCAN);
      busy      <= (state_nx == S_CPURST) ||
                   (state_nx == S_RUN) ||
                   (state_nx == S_SCAN);
      done      <= (state_nx == S_DONE);
    end
  end

  // Scan index and read-latency wait; index rests at 0 outside SCAN.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      test_reg <= '0;
      lat_cnt  <= '0;
    end else if (state == S_SCAN) begin
      if (cmp_now) begin
        lat_cnt  <= '0;
        test_reg <= last_reg ? '0 : test_reg + IDX_ONE;
      end else begin
        lat_cnt <= lat_cnt + LAT_ONE;
      end
    end else begin
      test_reg <= '0;
      lat_cnt  <= '0;
    end
  end

  // Next error tally and first failing index.
  always_comb begin
    err_nx = error_count;
    ff_nx  = first_fail_reg;
    if (enter_rst) begin
      err_nx = '0;
      ff_nx  = '0;
    end else if (scan_hit && mismatch) begin
      err_nx = error_count + ERR_ONE;
      if (error_count == '0) ff_nx = test_reg;
    end
  end

  // Result registers; pass is only ever set while in DONE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      error_count    <= '0;
      first_fail_reg <= '0;
      pass           <= 1'b0;
    end else begin
      error_count    <= err_nx;
      first_fail_reg <= ff_nx;
      pass           <= (state_nx == S_DONE) &&
                        (err_nx == '0);
    end
  end

  // Processor cycles executed in RUN.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_count <= '0;
    end else if (enter_rst) begin
      cycle_count <= '0;
    end else if (state == S_RUN) begin
      cycle_count <= cyc_inc[CYCLE_W-1:0];
    end
  end

`ifdef REGCHK_WB_MONITOR_EN
  localparam logic [CYCLE_W-1:0] WB_ONE = CYCLE_W'(1);

  logic wb_hit;

  assign wb_hit = (state == S_RUN) && wb_we &&
                  (wb_rd != '0);

  // Saturating count of real writebacks during RUN.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_count <= '0;
    end else if (enter_rst) begin
      wb_count <= '0;
    end else if (wb_hit && (wb_count != '1)) begin
      wb_count <= wb_count + WB_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_reg_check_harness.sv
// tb_reg_check_harness: two harness instances (read latency 0 and 2)
// driven together and checked against a register-array reference model.
module tb_reg_check_harness;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int CW = 8;
  localparam int AW = 5;
  localparam int EW = 6;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [CW-1:0] run_cycles = '0;

  always #5 clock = ~clock;

  logic          cpu_reset_a, cpu_en_a, test_mode_a;
  logic          busy_a, done_a, pass_a;
  logic [AW-1:0] test_reg_a, first_fail_a;
  logic [EW-1:0] error_count_a;
  logic [CW-1:0] cycle_count_a;
  logic [DW-1:0] reg_data_a, exp_data_a;

  logic          cpu_reset_b, cpu_en_b, test_mode_b;
  logic          busy_b, done_b, pass_b;
  logic [AW-1:0] test_reg_b, first_fail_b;
  logic [EW-1:0] error_count_b;
  logic [CW-1:0] cycle_count_b;
  logic [DW-1:0] reg_data_b, exp_data_b;

`ifdef REGCHK_WB_MONITOR_EN
  logic          wb_we = 1'b0;
  logic [AW-1:0] wb_rd = '0;
  logic [CW-1:0] wb_count_a, wb_count_b;
  int            m_wb_exp;
`endif

  logic [DW-1:0] rf  [NR];
  logic [DW-1:0] rom [NR];
  logic [DW-1:0] d1, d2;

  assign reg_data_a = rf[test_reg_a];
  assign exp_data_a = rom[test_reg_a];
  assign exp_data_b = rom[test_reg_b];
  assign reg_data_b = d2;

  // Two-cycle regfile read path for the latency-2 instance.
  always @(posedge clock) begin
    d1 <= rf[test_reg_b];
    d2 <= d1;
  end

  reg_check_harness #(
    .DATA_WIDTH(DW), .NUM_REGS(NR),
    .CYCLE_W(CW), .READ_LATENCY(0)
  ) u_a (
    .clock(clock), .reset(reset),
    .start(start), .run_cycles(run_cycles),
    .cpu_reset(cpu_reset_a), .cpu_en(cpu_en_a),
    .test_mode(test_mode_a), .test_reg(test_reg_a),
    .reg_data(reg_data_a), .exp_data(exp_data_a),
`ifdef REGCHK_WB_MONITOR_EN
    .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_count(wb_count_a),
`endif
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .error_count(error_count_a),
    .first_fail_reg(first_fail_a),
    .cycle_count(cycle_count_a)
  );

  reg_check_harness #(
    .DATA_WIDTH(DW), .NUM_REGS(NR),
    .CYCLE_W(CW), .READ_LATENCY(2)
  ) u_b (
    .clock(clock), .reset(reset),
    .start(start), .run_cycles(run_cycles),
    .cpu_reset(cpu_reset_b), .cpu_en(cpu_en_b),
    .test_mode(test_mode_b), .test_reg(test_reg_b),
    .reg_data(reg_data_b), .exp_data(exp_data_b),
`ifdef REGCHK_WB_MONITOR_EN
    .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_count(wb_count_b),
`endif
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .error_count(error_count_b),
    .first_fail_reg(first_fail_b),
    .cycle_count(cycle_count_b)
  );

  int errors = 0;
  int checks = 0;

  int m_busy1, m_rst1, m_rst2, m_done0, m_done1;
  int m_en_first, m_en_a, m_en_b;
  int m_tm_a, m_tm_b, m_done_a, m_done_b;

  // Fill ROM randomly; registers set in mask differ from ROM.
  task automatic set_rf(input logic [NR-1:0] mask);
    logic [DW-1:0] v;
    for (int i = 0; i < NR; i++) begin
      rom[i] = $urandom;
      v = $urandom;
      if (v == '0) v = 32'h1;
      rf[i] = mask[i] ? (rom[i] ^ v) : rom[i];
    end
  endtask

  // Reference: count differing registers, lowest differing index.
  task automatic model(output int e, output int f);
    e = 0;
    f = 0;
    for (int i = 0; i < NR; i++) begin
      if (rf[i] !== rom[i]) begin
        if (e == 0) f = i;
        e++;
      end
    end
  endtask

  // Pulse start and observe both instances until both report done.
  // Sample s is taken at the falling edge after rising edge k+s,
  // where edge k is the one that sees start.
  task automatic do_run(input int n, input int wbm, input bit extra);
    int s;
    int lim;
    lim = 2 + n + NR * 3 + 10;
    m_busy1 = 0; m_rst1 = 0; m_rst2 = 0;
    m_done0 = 0; m_done1 = 0;
    m_en_first = -1; m_en_a = 0; m_en_b = 0;
    m_tm_a = 0; m_tm_b = 0;
    m_done_a = -1; m_done_b = -1;
`ifdef REGCHK_WB_MONITOR_EN
    m_wb_exp = 0;
`endif
    @(negedge clock);
    start = 1'b1;
    run_cycles = CW'(n);
    s = 0;
    forever begin
      @(negedge clock);
      start = extra && (s == 3 || s == 5 || s == 8 ||
                        s == 12 || s == 30);
      if (s == 0) m_done0 = int'(done_a);
      if (s == 1) begin
        m_busy1 = int'(busy_a & busy_b);
        m_rst1  = int'(cpu_reset_a);
        m_done1 = int'(done_a);
      end
      if (s == 2) m_rst2 = int'(cpu_reset_a);
      if (cpu_en_a) begin
        m_en_a++;
        if (m_en_first < 0) m_en_first = s;
      end
      if (cpu_en_b) m_en_b++;
      if (test_mode_a) m_tm_a++;
      if (test_mode_b) m_tm_b++;
      if (s >= 1 && done_a && m_done_a < 0) m_done_a = s;
      if (s >= 1 && done_b && m_done_b < 0) m_done_b = s;
`ifdef REGCHK_WB_MONITOR_EN
      wb_we = (wbm == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      if (wbm == 1)
        wb_rd = (s == 3 || s == 6) ? '0 : AW'($urandom_range(1, NR - 1));
      else
        wb_rd = AW'($urandom_range(0, 3));
      if (s >= 2 && s <= n + 1 && wb_we && wb_rd != '0 &&
          m_wb_exp < 255)
        m_wb_exp++;
`endif
      if (m_done_a >= 0 && m_done_b >= 0) break;
      if (s >= lim) break;
      s++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    checks++;
    if ({cpu_reset_a, cpu_en_a, test_mode_a, busy_a, done_a, pass_a} !== 6'b100000) begin
      errors++;
      $display("FAIL rst_ctrl_a: got %b want 100000",
        {cpu_reset_a, cpu_en_a, test_mode_a, busy_a, done_a, pass_a});
    end
    checks++;
    if ({cpu_reset_b, cpu_en_b, test_mode_b, busy_b, done_b, pass_b} !== 6'b100000) begin
      errors++;
      $display("FAIL rst_ctrl_b: got %b want 100000",
        {cpu_reset_b, cpu_en_b, test_mode_b, busy_b, done_b, pass_b});
    end
    checks++;
    if ({test_reg_a, first_fail_a, error_count_a, cycle_count_a} !== '0) begin
      errors++;
      $display("FAIL rst_regs_a: got %h want 0",
        {test_reg_a, first_fail_a, error_count_a, cycle_count_a});
    end
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({cpu_reset_a, busy_a, done_a} !== 3'b100) begin
      errors++;
      $display("FAIL idle_after_rst: got %b want 100",
        {cpu_reset_a, busy_a, done_a});
    end
  endtask

  task automatic test_start_in_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    start = 1'b1;
    run_cycles = 8'd3;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    checks++;
    if ({busy_a, busy_b, cpu_en_a, cpu_reset_a} !== 4'b0001) begin
      errors++;
      $display("FAIL start_in_reset: got %b want 0001",
        {busy_a, busy_b, cpu_en_a, cpu_reset_a});
    end
  endtask

  task automatic test_pass_run();
    int e, f;
    set_rf('0);
    model(e, f);
    do_run(10, 0, 1'b0);
    checks++;
    if (m_busy1 !== 1 || m_rst1 !== 1 || m_rst2 !== 0) begin
      errors++;
      $display("FAIL pass_start: busy1=%0d rst1=%0d rst2=%0d want 1 1 0",
        m_busy1, m_rst1, m_rst2);
    end
    checks++;
    if (m_en_first !== 2 || m_en_a !== 10 || m_en_b !== 10) begin
      errors++;
      $display("FAIL pass_en: first=%0d a=%0d b=%0d want 2 10 10",
        m_en_first, m_en_a, m_en_b);
    end
    checks++;
    if (m_tm_a !== NR || m_done_a !== 2 + 10 + NR) begin
      errors++;
      $display("FAIL pass_scan_a: tm=%0d done=%0d want %0d %0d",
        m_tm_a, m_done_a, NR, 2 + 10 + NR);
    end
    checks++;
    if ({pass_a, pass_b} !== 2'b11 || 32'(error_count_a) !== e) begin
      errors++;
      $display("FAIL pass_result: pass=%b err=%0d want 11 %0d",
        {pass_a, pass_b}, error_count_a, e);
    end
    checks++;
    if (32'(cycle_count_a) !== 10 || 32'(cycle_count_b) !== 10) begin
      errors++;
      $display("FAIL pass_cycles: got %0d %0d want 10",
        cycle_count_a, cycle_count_b);
    end
    repeat (5) @(negedge clock);
    checks++;
    if ({done_a, pass_a, busy_a, test_mode_a, cpu_en_a, cpu_reset_a} !== 6'b110000) begin
      errors++;
      $display("FAIL done_hold: got %b want 110000",
        {done_a, pass_a, busy_a, test_mode_a, cpu_en_a, cpu_reset_a});
    end
  endtask

  task automatic test_mismatch();
    int e, f, n;
    set_rf(32'h0002_0020);
    model(e, f);
    n = $urandom_range(1, 15);
    do_run(n, 0, 1'b0);
    checks++;
    if (32'(error_count_a) !== e || 32'(first_fail_a) !== f || pass_a !== 1'b0) begin
      errors++;
      $display("FAIL mism_a: err=%0d ff=%0d pass=%b want %0d %0d 0",
        error_count_a, first_fail_a, pass_a, e, f);
    end
    checks++;
    if (32'(error_count_b) !== 2 || 32'(first_fail_b) !== 5 || pass_b !== 1'b0) begin
      errors++;
      $display("FAIL mism_b: err=%0d ff=%0d pass=%b want 2 5 0",
        error_count_b, first_fail_b, pass_b);
    end
    checks++;
    if (m_en_a !== n || 32'(cycle_count_a) !== n) begin
      errors++;
      $display("FAIL mism_run: en=%0d cyc=%0d want %0d",
        m_en_a, cycle_count_a, n);
    end
  endtask

  task automatic test_latency();
    set_rf(32'h8000_0000);
    do_run(6, 0, 1'b0);
    checks++;
    if (m_tm_b !== 96 || m_done_b !== 2 + 6 + 96) begin
      errors++;
      $display("FAIL lat_scan: tm=%0d done=%0d want 96 %0d",
        m_tm_b, m_done_b, 2 + 6 + 96);
    end
    checks++;
    if (32'(error_count_b) !== 1 || 32'(first_fail_b) !== 31 || pass_b !== 1'b0) begin
      errors++;
      $display("FAIL lat_result: err=%0d ff=%0d pass=%b want 1 31 0",
        error_count_b, first_fail_b, pass_b);
    end
    checks++;
    if (32'(error_count_a) !== 1 || 32'(first_fail_a) !== 31) begin
      errors++;
      $display("FAIL lat0_result: err=%0d ff=%0d want 1 31",
        error_count_a, first_fail_a);
    end
  endtask

  task automatic test_sign_reg0();
    set_rf(32'h8000_0000);
    rom[0] = 32'h0000_0005;
    rf[0]  = 32'h8000_0005;
    do_run(3, 0, 1'b0);
    checks++;
    if (32'(error_count_a) !== 2 || 32'(first_fail_a) !== 0) begin
      errors++;
      $display("FAIL reg0_a: err=%0d ff=%0d want 2 0",
        error_count_a, first_fail_a);
    end
    checks++;
    if (32'(error_count_b) !== 2 || 32'(first_fail_b) !== 0) begin
      errors++;
      $display("FAIL reg0_b: err=%0d ff=%0d want 2 0",
        error_count_b, first_fail_b);
    end
  endtask

  task automatic test_zero_run();
    int e, f;
    set_rf(32'h0000_0100);
    model(e, f);
    do_run(0, 0, 1'b0);
    checks++;
    if (m_en_first !== -1 || m_en_a !== 0 || m_en_b !== 0) begin
      errors++;
      $display("FAIL zero_en: first=%0d a=%0d b=%0d want -1 0 0",
        m_en_first, m_en_a, m_en_b);
    end
    checks++;
    if (m_done_a !== 2 + NR || m_done_b !== 2 + NR * 3 || m_rst2 !== 0) begin
      errors++;
      $display("FAIL zero_done: a=%0d b=%0d rst2=%0d want %0d %0d 0",
        m_done_a, m_done_b, m_rst2, 2 + NR, 2 + NR * 3);
    end
    checks++;
    if (32'(cycle_count_a) !== 0 || 32'(error_count_a) !== e || 32'(first_fail_a) !== f) begin
      errors++;
      $display("FAIL zero_result: cyc=%0d err=%0d ff=%0d want 0 %0d %0d",
        cycle_count_a, error_count_a, first_fail_a, e, f);
    end
  endtask

  task automatic test_max_run();
    do_run(255, 0, 1'b0);
    checks++;
    if (m_en_a !== 255 || 32'(cycle_count_a) !== 255 || 32'(cycle_count_b) !== 255) begin
      errors++;
      $display("FAIL max_run: en=%0d cyc=%0d %0d want 255",
        m_en_a, cycle_count_a, cycle_count_b);
    end
    checks++;
    if (m_done_a !== 2 + 255 + NR) begin
      errors++;
      $display("FAIL max_done: got %0d want %0d", m_done_a, 2 + 255 + NR);
    end
  endtask

  task automatic test_random();
    int e, f, n;
    logic [NR-1:0] mask;
    for (int it = 0; it < 6; it++) begin
      mask = (it == 0) ? '0 : ($urandom & $urandom & $urandom);
      set_rf(mask);
      model(e, f);
      n = $urandom_range(0, 30);
      do_run(n, 0, 1'b0);
      checks++;
      if (32'(error_count_a) !== e || 32'(first_fail_a) !== f ||
          pass_a !== (e == 0)) begin
        errors++;
        $display("FAIL rand_a[%0d]: err=%0d ff=%0d pass=%b want %0d %0d",
          it, error_count_a, first_fail_a, pass_a, e, f);
      end
      checks++;
      if (32'(error_count_b) !== e || 32'(first_fail_b) !== f ||
          pass_b !== (e == 0)) begin
        errors++;
        $display("FAIL rand_b[%0d]: err=%0d ff=%0d pass=%b want %0d %0d",
          it, error_count_b, first_fail_b, pass_b, e, f);
      end
      checks++;
      if (m_en_a !== n || m_done_a !== 2 + n + NR || m_done_b !== 2 + n + NR * 3) begin
        errors++;
        $display("FAIL rand_time[%0d]: en=%0d da=%0d db=%0d n=%0d",
          it, m_en_a, m_done_a, m_done_b, n);
      end
    end
  endtask

  task automatic test_abort_restart();
    int e, f;
    set_rf(32'h0000_0f0f);
    model(e, f);
    @(negedge clock);
    start = 1'b1;
    run_cycles = 8'd5;
    @(negedge clock);
    start = 1'b0;
    repeat (20) @(negedge clock);
    checks++;
    if ({test_mode_a, test_mode_b} !== 2'b11) begin
      errors++;
      $display("FAIL abort_pre: test_mode=%b want 11",
        {test_mode_a, test_mode_b});
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({cpu_reset_a, cpu_en_a, test_mode_a, busy_a, done_a, pass_a} !== 6'b100000 ||
        {cpu_reset_b, cpu_en_b, test_mode_b, busy_b, done_b, pass_b} !== 6'b100000) begin
      errors++;
      $display("FAIL abort_ctrl: got %b %b want 100000",
        {cpu_reset_a, cpu_en_a, test_mode_a, busy_a, done_a, pass_a},
        {cpu_reset_b, cpu_en_b, test_mode_b, busy_b, done_b, pass_b});
    end
    checks++;
    if ({test_reg_a, first_fail_a, error_count_a, cycle_count_a} !== '0 ||
        {test_reg_b, first_fail_b, error_count_b, cycle_count_b} !== '0) begin
      errors++;
      $display("FAIL abort_regs: err=%0d %0d cyc=%0d want 0",
        error_count_a, error_count_b, cycle_count_a);
    end
    @(negedge clock);
    reset = 1'b1;
    do_run(20, 0, 1'b1);
    checks++;
    if (m_en_a !== 20 || m_done_a !== 2 + 20 + NR || m_done_b !== 2 + 20 + NR * 3) begin
      errors++;
      $display("FAIL extra_start: en=%0d da=%0d db=%0d want 20 %0d %0d",
        m_en_a, m_done_a, m_done_b, 2 + 20 + NR, 2 + 20 + NR * 3);
    end
    checks++;
    if (32'(error_count_a) !== e || 32'(first_fail_a) !== f) begin
      errors++;
      $display("FAIL extra_result: err=%0d ff=%0d want %0d %0d",
        error_count_a, first_fail_a, e, f);
    end
  endtask

  task automatic test_restart_from_done();
    int e, f;
    set_rf('0);
    model(e, f);
    do_run(4, 0, 1'b0);
    checks++;
    if (m_done0 !== 1 || m_done1 !== 0 || m_busy1 !== 1) begin
      errors++;
      $display("FAIL restart_edge: d0=%0d d1=%0d busy1=%0d want 1 0 1",
        m_done0, m_done1, m_busy1);
    end
    checks++;
    if (32'(error_count_a) !== e || pass_a !== 1'b1 || 32'(first_fail_a) !== 0) begin
      errors++;
      $display("FAIL restart_result: err=%0d pass=%b ff=%0d want 0 1 0",
        error_count_a, pass_a, first_fail_a);
    end
  endtask

`ifdef REGCHK_WB_MONITOR_EN
  task automatic test_wb_monitor();
    set_rf('0);
    do_run(7, 1, 1'b0);
    checks++;
    if (32'(wb_count_a) !== 5 || 32'(wb_count_b) !== 5) begin
      errors++;
      $display("FAIL wb_plan: got %0d %0d want 5", wb_count_a, wb_count_b);
    end
    do_run($urandom_range(5, 40), 0, 1'b0);
    checks++;
    if (32'(wb_count_a) !== m_wb_exp) begin
      errors++;
      $display("FAIL wb_rand: got %0d want %0d", wb_count_a, m_wb_exp);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_start_in_reset();
    test_pass_run();
    test_mismatch();
    test_latency();
    test_sign_reg0();
    test_zero_run();
    test_max_run();
    test_random();
    test_abort_restart();
    test_restart_from_done();
`ifdef REGCHK_WB_MONITOR_EN
    test_wb_monitor();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/reg_check_harness.md
# reg_check_harness

Synthesizable successor to the simulation-only register check harness, for on-board self-test of the processor. After a `start` pulse it:
- holds the processor in reset for one cycle, then runs it for a programmable number of cycles;
- freezes the processor and takes over regfile read port A;
- scans every architectural register against an expected-value ROM, counting mismatches and latching the first failing index.

It sits between the processor, the regfile port-A address mux and an expected-value ROM inside the FPGA wrapper. Register count, data width and regfile read latency are all parameters.

## Interface
Parameters:
- `DATA_WIDTH`, 32, register width.
- `NUM_REGS`, 32, registers scanned, indices 0..NUM_REGS-1; must be ≥ 2.
- `CYCLE_W`, 16, width of the run-cycle counter.
- `READ_LATENCY`, 0, regfile read latency in cycles, legal range 0..3.
- `ADDR_W`, `$clog2(NUM_REGS)`, width of register indices.
- `ERR_W`, `$clog2(NUM_REGS+1)`, width of the error counter.

Ports:
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `start` in 1: single-cycle request to begin a test.
- `run_cycles` in CYCLE_W: processor cycles to execute; sampled at start acceptance.
- `cpu_reset` out 1: processor reset.
- `cpu_en` out 1: processor clock enable.
- `test_mode` out 1: steers regfile port A to `test_reg`.
- `test_reg` out ADDR_W: register index under test; also the expected-ROM address.
- `reg_data` in DATA_WIDTH: regfile port A data.
- `exp_data` in DATA_WIDTH: expected value, combinational from `test_reg`.
- `busy` out 1: high while a test is in progress.
- `done` out 1: test complete.
- `pass` out 1: test passed; meaningful only while `done`=1.
- `error_count` out ERR_W: number of mismatching registers.
- `first_fail_reg` out ADDR_W: lowest failing register index.
- `cycle_count` out CYCLE_W: processor cycles executed in RUN.

## Operation
- **States:** IDLE, CPURST, RUN, SCAN, DONE.
- **IDLE:**
  - `cpu_reset`=1, `cpu_en`=0.
  - `start`=1 moves to CPURST and latches `run_cycles`.
  - Entering CPURST clears `error_count`, `first_fail_reg`, `cycle_count` and `done`.
- **CPURST:**
  - `cpu_reset`=1 for exactly one cycle.
  - Next state is RUN, or SCAN if the latched count is 0.
- **RUN:**
  - `cpu_reset`=0, `cpu_en`=1.
  - `cycle_count` increments every cycle.
  - Moves to SCAN when `cycle_count` reaches the latched count.
- **SCAN:**
  - `cpu_en`=0, which freezes the processor; `test_mode`=1.
  - `test_reg` starts at 0.
  - A latency counter waits READ_LATENCY cycles, then one compare cycle samples `reg_data` against `exp_data`.
  - Mismatch: `error_count`+1; `first_fail_reg` is written only while `error_count`==0.
  - Then `test_reg` increments.
  - After the compare of NUM_REGS-1, moves to DONE.
- **DONE:**
  - `done`=1, `busy`=0, `pass`=(`error_count`==0).
  - `test_mode`=0, `cpu_en`=0, `cpu_reset`=0.
  - Results hold until the next accepted `start`, which moves to CPURST.
- **Comparison:** bitwise over the full DATA_WIDTH, with no sign handling. Register 0 is compared like any other.
- **Busy window:** `busy`=1 in CPURST, RUN and SCAN. `start` is ignored while busy.

## Timing
- **Reset values:**
  - IDLE; `cpu_reset`=1; `cpu_en`=0; `test_mode`=0; `test_reg`=0.
  - `busy`=0, `done`=0, `pass`=0.
  - `error_count`=0, `first_fail_reg`=0, `cycle_count`=0.
- **Output type:** all outputs are registered.
- **Start latency:** with `start` high at edge k, `cpu_reset` is high during cycle k+1 (CPURST) and `cpu_en` rises at edge k+2.
- **RUN length:** `cpu_en` is high for exactly `run_cycles` cycles. `run_cycles`=2^CYCLE_W-1 must work without counter wrap.
- **Scan length:** SCAN lasts NUM_REGS×(READ_LATENCY+1) cycles.
- **Compare alignment:** the compare for index i uses `reg_data` sampled at the edge that ends the latency wait for i, and `test_reg` is stable through that edge.
- **Start during reset:** while `reset` is low, `start` is ignored.
- **Reset mid-test:** asserting `reset` in any state returns to IDLE asynchronously with reset values and discards partial results.
- **Start in DONE:** `start` in DONE restarts the test; `done` falls on the same edge that enters CPURST.

## Configuration
- **Macro:** `REGCHK_WB_MONITOR_EN`.
- **When defined, adds ports:**
  - inputs `wb_we` (1) and `wb_rd` (ADDR_W);
  - output `wb_count` (CYCLE_W).
- **`wb_count` behaviour:**
  - counts RUN cycles with `wb_we`=1 and `wb_rd`≠0;
  - clears on entry to CPURST and reset value is 0;
  - saturates at all-ones.
- **When undefined:** these ports and their logic are absent. All other behaviour is identical.

## Test plan
- **Pass run:** NUM_REGS=32, READ_LATENCY=0, `run_cycles`=10, regfile model equal to ROM.
  - Expected: `cpu_en` high exactly 10 cycles; `done` 32 cycles after RUN ends; `pass`=1, `error_count`=0, `cycle_count`=10.
- **Mismatches:** reg 5 and reg 17 differ from ROM.
  - Expected: `error_count`=2, `first_fail_reg`=5, `pass`=0.
- **Read latency:** READ_LATENCY=2 with a 2-cycle regfile model, reg 31 mismatching.
  - Expected: SCAN lasts 96 cycles; `error_count`=1, `first_fail_reg`=31.
- **Zero run:** `run_cycles`=0.
  - Expected: `cpu_en` never rises; CPURST goes straight to SCAN; `cycle_count`=0.
- **Abort and restart:** `reset` pulsed low mid-SCAN, then `start` pulsed repeatedly during RUN.
  - Expected: all outputs return to reset values immediately; the extra `start` pulses have no effect.
  - A restart from DONE clears `done` at CPURST entry.
- **Writeback monitor:** with `REGCHK_WB_MONITOR_EN`, drive 7 RUN cycles with `wb_we`=1, of which 2 have `wb_rd`=0.
  - Expected: `wb_count`=5.
